// File: rtl/burst_seq_ctrl.sv
// burst_seq_ctrl
// Counted data-burst sequencer for the burst_mode / irdy / trdy bus phase.
// A burst is requested in IDLE, runs beat by beat in XFER (a beat is a cycle
// with irdy && trdy), and is followed by a fixed recovery window in which both
// ready lines are forced low and burst_mode stays low. The window starts on,
// and includes, the cycle in which burst_mode falls.
//
// The registered outputs (burst_mode, busy, done, beat_cnt) are computed one
// cycle ahead in the next-state logic and captured in the state register.
// As a result, each one changes together with the state it describes.
// irdy and trdy are combinational so that reset removes them immediately,
// without waiting for a clock edge.

module burst_seq_ctrl #(
    parameter int LEN_W       = 4,
    parameter int RECOVER_CYC = 9
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             m_valid,
    input  logic             t_ready,
    input  logic             abort,
    output logic             burst_mode,
    output logic             irdy,
    output logic             trdy,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] beat_cnt
);

    // Recovery counter just wide enough to hold RECOVER_CYC-1.
    localparam int RC_W = (RECOVER_CYC > 2) ? $clog2(RECOVER_CYC) : 1;

    localparam logic [RC_W-1:0]  REC_LOAD = RC_W'(RECOVER_CYC - 1);
    localparam logic [RC_W-1:0]  REC_ONE  = RC_W'(1'b1);
    localparam logic [RC_W-1:0]  REC_ZERO = {RC_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_XFER    = 2'b01,
        ST_RECOVER = 2'b10
    } state_e;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_nxt_s;
    logic [LEN_W-1:0] beat_cnt_r;
    logic [LEN_W-1:0] beat_cnt_nxt_s;
    logic [RC_W-1:0]  rec_cnt_r;
    logic [RC_W-1:0]  rec_cnt_nxt_s;
    logic             burst_mode_r;
    logic             burst_mode_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    logic             in_xfer_s;
    logic             irdy_s;
    logic             trdy_s;
    logic             beat_s;
    logic             last_beat_s;

    // Bus-phase qualifiers: ready lines are live only in XFER and out of reset.
    always_comb begin
        in_xfer_s   = (state_r == ST_XFER);
        irdy_s      = rst_n & in_xfer_s & m_valid;
        trdy_s      = rst_n & in_xfer_s & t_ready;
        beat_s      = irdy_s & trdy_s;
        // The final beat fires while the counter still shows len-1, so the
        // counter can never step past len and never wraps.
        last_beat_s = beat_s & (beat_cnt_r == (len_r - LEN_ONE));
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        len_nxt_s        = len_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        rec_cnt_nxt_s    = rec_cnt_r;
        burst_mode_nxt_s = 1'b0;
        busy_nxt_s       = 1'b0;
        done_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A zero-length request carries no beats and is dropped.
                if (start && (len != LEN_ZERO)) begin
                    state_nxt_s      = ST_XFER;
                    len_nxt_s        = len;
                    beat_cnt_nxt_s   = LEN_ZERO;
                    burst_mode_nxt_s = 1'b1;
                    busy_nxt_s       = 1'b1;
                end else begin
                    state_nxt_s      = ST_IDLE;
                end
            end

            ST_XFER: begin
                busy_nxt_s = 1'b1;
                // A beat that coincides with abort still counts.
                if (beat_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + LEN_ONE;
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end

                if (last_beat_s || abort) begin
                    state_nxt_s      = ST_RECOVER;
                    rec_cnt_nxt_s    = REC_LOAD;
                    done_nxt_s       = 1'b1;
                    burst_mode_nxt_s = 1'b0;
                end else begin
                    state_nxt_s      = ST_XFER;
                    burst_mode_nxt_s = 1'b1;
                end
            end

            ST_RECOVER: begin
                // The counter is loaded with RECOVER_CYC-1 on the fall cycle,
                // so reaching zero marks the last recovery cycle.
                if (rec_cnt_r == REC_ZERO) begin
                    state_nxt_s   = ST_IDLE;
                    busy_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s   = ST_RECOVER;
                    rec_cnt_nxt_s = rec_cnt_r - REC_ONE;
                    busy_nxt_s    = 1'b1;
                end
            end

            default: begin
                // An unreachable encoding falls back to a quiet IDLE.
                state_nxt_s   = ST_IDLE;
                rec_cnt_nxt_s = REC_ZERO;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            len_r        <= LEN_ZERO;
            beat_cnt_r   <= LEN_ZERO;
            rec_cnt_r    <= REC_ZERO;
            burst_mode_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            len_r        <= len_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            rec_cnt_r    <= rec_cnt_nxt_s;
            burst_mode_r <= burst_mode_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign burst_mode = burst_mode_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign beat_cnt   = beat_cnt_r;
    assign irdy       = irdy_s;
    assign trdy       = trdy_s;

endmodule
